// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register file.
// Combinational only: no latency, no backpressure.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_IDX       = 4'd3,
    ST_IDX_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8
  } i2c_state_e;

  localparam logic       I2C_ACK      = 1'b0;
  localparam logic       I2C_NACK     = 1'b1;
  localparam logic [7:0] OOR_READ_VAL = 8'hFF;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Pad-line conditioner: 2-flop synchroniser, optional majority filter (I2C_GLITCH_FILTER_EN), edge pulses.
// Latency 2 clk to lvl_o (4 clk with the filter); no backpressure, samples every clk.
module i2c_line_cond
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
  logic lvl;

`ifdef I2C_GLITCH_FILTER_EN
  logic h1_q, h1_d, h2_q, h2_d, filt_q, filt_d;

  always_comb begin
    h1_d   = s2_q;
    h2_d   = h1_q;
    filt_d = majority3(s2_q, h1_q, h2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_q   <= 1'b1;
      h2_q   <= 1'b1;
      filt_q <= 1'b1;
    end else begin
      h1_q   <= h1_d;
      h2_q   <= h2_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  always_comb begin
    s1_d   = line_i;
    s2_d   = s1_q;
    prev_d = lvl;
  end

  // Idle bus is high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign lvl_o  = lvl;
  assign rise_o = lvl & ~prev_q;
  assign fall_o = ~lvl & prev_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// Oversampled I2C target with 8-bit register file, hw write port; I2C_GLITCH_FILTER_EN adds input filtering.
// Latency: reacts 2-3 clk after a pad edge; no backpressure, the I2C master owns the pace.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h55,
  parameter int         NUM_REGS = 4,
  parameter int         AUTO_INC = 1,
  parameter logic [7:0] RST_VAL  = 8'h00,
  localparam int        IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic                  wr_stb_o,
  output logic [IDX_W-1:0]      wr_idx_o,
  input  logic                  hw_we,
  input  logic [IDX_W-1:0]      hw_idx,
  input  logic [7:0]            hw_wdata,
  output logic                  busy_o
);

  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [7:0] IDX_LAST   = 8'(NUM_REGS - 1);

  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;

  i2c_line_cond u_scl (.clk(clk), .rst_n(rst_n), .line_i(scl_i),
                       .lvl_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
  i2c_line_cond u_sda (.clk(clk), .rst_n(rst_n), .line_i(sda_i),
                       .lvl_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

  i2c_state_e       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d, idx_q, idx_d;
  logic             rw_q, rw_d, done_q, done_d, oe_q, oe_d, busy_q, busy_d;
  logic             wr_stb_q, wr_stb_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]       regs_q [NUM_REGS];
  logic [7:0]       regs_d [NUM_REGS];

  logic       start_det, stop_det, in_range, i2c_we;
  logic [7:0] idx_next, rd_byte;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign in_range  = {1'b0, idx_q} < NUM_REGS_W;

  always_comb begin
    idx_next = idx_q;
    if ((AUTO_INC != 0) && in_range) idx_next = (idx_q == IDX_LAST) ? 8'd0 : idx_q + 8'd1;
    rd_byte = OOR_READ_VAL;
    for (int k = 0; k < NUM_REGS; k++) if (idx_q == 8'(k)) rd_byte = regs_q[k];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    rw_d     = rw_q;
    done_d   = done_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    wr_stb_d = 1'b0;
    wr_idx_d = wr_idx_q;
    i2c_we   = 1'b0;
    if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = 3'd0;
      done_d  = 1'b0;
      oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_IDX, ST_WDATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_lvl};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) done_d = 1'b1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_d = ST_ADDR_ACK;
                oe_d    = 1'b1;
                busy_d  = 1'b1;
                rw_d    = shift_q[0];
              end else begin
                state_d = ST_IDLE;
              end
            end else if (state_q == ST_IDX) begin
              idx_d   = shift_q;
              state_d = ST_IDX_ACK;
              oe_d    = 1'b1;
            end else if (in_range) begin
              i2c_we   = 1'b1;
              wr_stb_d = 1'b1;
              wr_idx_d = idx_q[IDX_W-1:0];
              idx_d    = idx_next;
              oe_d     = 1'b1;
              state_d  = ST_WDATA_ACK;
            end else begin
              oe_d    = 1'b0;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        ST_ADDR_ACK, ST_RDATA_ACK: begin
          if (state_q == ST_RDATA_ACK && scl_rise) begin
            if (sda_lvl == I2C_NACK) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              done_d = 1'b1;
            end
          end else if (scl_fall && (state_q == ST_ADDR_ACK || done_q)) begin
            done_d = 1'b0;
            cnt_d  = 3'd0;
            // Snapshot the read byte now so hw writes cannot disturb it mid-byte.
            if (state_q == ST_RDATA_ACK || rw_q) begin
              state_d = ST_RDATA;
              shift_d = {rd_byte[6:0], 1'b0};
              oe_d    = ~rd_byte[7];
              cnt_d   = 3'd1;
            end else begin
              state_d = ST_IDX;
              oe_d    = 1'b0;
            end
          end
        end
        ST_IDX_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state_d = ST_WDATA;
            oe_d    = 1'b0;
            cnt_d   = 3'd0;
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              state_d = ST_RDATA_ACK;
              oe_d    = 1'b0;
              idx_d   = idx_next;
            end else begin
              oe_d    = ~shift_q[7];
              shift_d = {shift_q[6:0], 1'b0};
              cnt_d   = cnt_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The I2C write is applied last so it wins a same-index collision.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
      if (hw_we && hw_idx == IDX_W'(k)) regs_d[k] = hw_wdata;
      if (i2c_we && idx_q == 8'(k))     regs_d[k] = shift_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      shift_q  <= 8'd0;
      idx_q    <= 8'd0;
      rw_q     <= 1'b0;
      done_q   <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      wr_stb_q <= 1'b0;
      wr_idx_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RST_VAL;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      rw_q     <= rw_d;
      done_q   <= done_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      wr_stb_q <= wr_stb_d;
      wr_idx_q <= wr_idx_d;
      regs_q   <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[8*g +: 8] = regs_q[g];
  end

  assign sda_oe   = oe_q;
  assign busy_o   = busy_q;
  assign wr_stb_o = wr_stb_q;
  assign wr_idx_o = wr_idx_q;

endmodule
